// File: rtl/exception_ctrl_pkg.sv
// Shared codes for the MEM-stage exception arbiter: excepttype values, CP0 addresses,
// raw flag positions, FSM states and the effective-CP0 bundle.
package exception_ctrl_pkg;

  localparam logic [31:0] EXCEPTTYPE_NONE         = 32'h0000_0000;
  localparam logic [31:0] EXCEPTTYPE_INT          = 32'h0000_0001;
  localparam logic [31:0] EXCEPTTYPE_SYSCALL      = 32'h0000_0008;
  localparam logic [31:0] EXCEPTTYPE_INST_INVALID = 32'h0000_000a;
  localparam logic [31:0] EXCEPTTYPE_TRAP         = 32'h0000_000d;
  localparam logic [31:0] EXCEPTTYPE_OV           = 32'h0000_000c;
  localparam logic [31:0] EXCEPTTYPE_ERET         = 32'h0000_000e;

  localparam logic [4:0] CP0_REG_STATUS = 5'd12;
  localparam logic [4:0] CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_REG_EPC    = 5'd14;

  localparam int FLAG_SYSCALL      = 8;
  localparam int FLAG_INST_INVALID = 9;
  localparam int FLAG_TRAP         = 10;
  localparam int FLAG_OV           = 11;
  localparam int FLAG_ERET         = 12;

  localparam logic [31:0] EXC_VECTOR_DEFAULT  = 32'h0000_0020;
  localparam int          HOLDOFF_CYC_DEFAULT = 4;

  // Software-writable Cause bits: IP1..IP0, WP, IV.
  localparam logic [31:0] CAUSE_WR_MASK = 32'h00c0_0300;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_HOLDOFF = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
  } cp0_regs_t;

  // Unmasked pending interrupt with IE set and EXL clear.
  function automatic logic int_pending(cp0_regs_t r);
    return (|(r.cause[15:8] & r.status[15:8])) && r.status[0] && !r.status[1];
  endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// Bundle between the MEM/WB pipeline + CP0 and the exception arbiter.
// master = pipeline/CP0 side, slave = arbiter.
interface exception_ctrl_if;

  logic        mem_valid_i;
  logic [31:0] mem_excepttype_i;
  logic [31:0] mem_inst_addr_i;
  logic        mem_is_in_delayslot_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] wb_cp0_data_i;

  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic        flush_o;
  logic [31:0] new_pc_o;

  modport master (
    output mem_valid_i, mem_excepttype_i, mem_inst_addr_i, mem_is_in_delayslot_i,
    output cp0_status_i, cp0_cause_i, cp0_epc_i,
    output wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o, flush_o, new_pc_o
  );

  modport slave (
    input  mem_valid_i, mem_excepttype_i, mem_inst_addr_i, mem_is_in_delayslot_i,
    input  cp0_status_i, cp0_cause_i, cp0_epc_i,
    input  wb_cp0_we_i, wb_cp0_waddr_i, wb_cp0_data_i,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o, flush_o, new_pc_o
  );

endinterface

// File: rtl/exception_ctrl_cp0_bypass.sv
// Effective Status/Cause/EPC: a WB-stage mtc0 overrides the CP0 register file value.
// Purely combinational, no state.
module exception_ctrl_cp0_bypass
  import exception_ctrl_pkg::*;
(
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_data,
  output cp0_regs_t   eff
);

  always_comb begin
    eff.status = cp0_status;
    eff.cause  = cp0_cause;
    eff.epc    = cp0_epc;
    if (wb_we && (wb_waddr == CP0_REG_STATUS)) begin
      eff.status = wb_data;
    end
    // Only the software-writable Cause bits come from the mtc0 data.
    if (wb_we && (wb_waddr == CP0_REG_CAUSE)) begin
      eff.cause = (cp0_cause & ~CAUSE_WR_MASK) | (wb_data & CAUSE_WR_MASK);
    end
    if (wb_we && (wb_waddr == CP0_REG_EPC)) begin
      eff.epc = wb_data;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// MEM-stage exception arbiter: encodes excepttype, flush and redirect PC combinationally in
// the MEM cycle; a holdoff FSM masks interrupts for HOLDOFF_CYC cycles after every flush.
module exception_ctrl
  import exception_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
  parameter int          HOLDOFF_CYC = HOLDOFF_CYC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  exception_ctrl_if.slave bus
);

  localparam int CNT_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLDOFF_CYC - 1);

  cp0_regs_t        eff;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             int_req_q;
  logic             int_cond;
  logic             int_take;
  logic [31:0]      exc_type;
  logic             flush;
  logic [31:0]      new_pc;
  logic [31:0]      flags;
  logic             unused_flags;

  exception_ctrl_cp0_bypass u_bypass (
    .cp0_status (bus.cp0_status_i),
    .cp0_cause  (bus.cp0_cause_i),
    .cp0_epc    (bus.cp0_epc_i),
    .wb_we      (bus.wb_cp0_we_i),
    .wb_waddr   (bus.wb_cp0_waddr_i),
    .wb_data    (bus.wb_cp0_data_i),
    .eff        (eff)
  );

  assign flags        = bus.mem_excepttype_i;
  assign unused_flags = ^{flags[31:13], flags[7:0]};

  assign int_cond = int_pending(eff);
  // Interrupt needs two consecutive qualifying cycles and no holdoff in progress.
  assign int_take = int_req_q && int_cond && bus.mem_valid_i && (state == ST_IDLE);

  always_comb begin
    exc_type = EXCEPTTYPE_NONE;
    if (!rst && bus.mem_valid_i) begin
      if (int_take)                     exc_type = EXCEPTTYPE_INT;
      else if (flags[FLAG_SYSCALL])      exc_type = EXCEPTTYPE_SYSCALL;
      else if (flags[FLAG_INST_INVALID]) exc_type = EXCEPTTYPE_INST_INVALID;
      else if (flags[FLAG_TRAP])         exc_type = EXCEPTTYPE_TRAP;
      else if (flags[FLAG_OV])           exc_type = EXCEPTTYPE_OV;
      else if (flags[FLAG_ERET])         exc_type = EXCEPTTYPE_ERET;
    end
  end

  always_comb begin
    flush  = (exc_type != EXCEPTTYPE_NONE);
    new_pc = '0;
    if (flush) begin
      new_pc = (exc_type == EXCEPTTYPE_ERET) ? eff.epc : EXC_VECTOR;
    end
  end

  assign bus.excepttype_o        = exc_type;
  assign bus.flush_o             = flush;
  assign bus.new_pc_o            = new_pc;
  assign bus.current_inst_addr_o = rst ? 32'h0 : bus.mem_inst_addr_i;
  assign bus.is_in_delayslot_o   = rst ? 1'b0 : bus.mem_is_in_delayslot_i;

  // Any flush (re)arms the holdoff, including synchronous exceptions taken mid-holdoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      int_req_q <= 1'b0;
    end else begin
      int_req_q <= int_cond;
      if (flush) begin
        state <= ST_HOLDOFF;
        cnt   <= CNT_RELOAD;
      end else if (state == ST_HOLDOFF) begin
        if (cnt == '0) begin
          state <= ST_IDLE;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl: stimulus pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_exception_ctrl;

  typedef struct {
    logic [31:0] et;
    logic [31:0] np;
    logic [31:0] addr;
    logic        ds;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t  exp_q[$];
  string name_q[$];

  exception_ctrl_if bus();

  exception_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic void cmp(string n, string f, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s.%s: got %h, expected %h", n, f, act, req);
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t  e;
    string n;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      cmp(n, "excepttype", bus.excepttype_o, e.et);
      cmp(n, "flush", {31'h0, bus.flush_o}, {31'h0, (e.et != 32'h0)});
      cmp(n, "new_pc", bus.new_pc_o, e.np);
      cmp(n, "inst_addr", bus.current_inst_addr_o, e.addr);
      cmp(n, "delayslot", {31'h0, bus.is_in_delayslot_o}, {31'h0, e.ds});
    end
  end

  task automatic mem(input logic v, input logic [31:0] fl, input logic [31:0] pc, input logic ds);
    bus.mem_valid_i           = v;
    bus.mem_excepttype_i      = fl;
    bus.mem_inst_addr_i       = pc;
    bus.mem_is_in_delayslot_i = ds;
  endtask

  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    bus.wb_cp0_we_i    = we;
    bus.wb_cp0_waddr_i = a;
    bus.wb_cp0_data_i  = d;
  endtask

  // Records the expectation for the current cycle, then advances to the next drive point.
  task automatic chk(input string n, input logic [31:0] et, input logic [31:0] np);
    exp_t e;
    e.et   = et;
    e.np   = np;
    e.addr = rst ? 32'h0 : bus.mem_inst_addr_i;
    e.ds   = rst ? 1'b0 : bus.mem_is_in_delayslot_i;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    mem(1'b0, 32'h0, 32'h0, 1'b0);
    wb(1'b0, 5'd0, 32'h0);
    bus.cp0_status_i = 32'h0;
    bus.cp0_cause_i  = 32'h0;
    bus.cp0_epc_i    = 32'h0;
    repeat (2) @(posedge clk);
    #1;

    // Outputs forced to zero while reset is held, even with a syscall presented.
    mem(1'b1, 32'h100, 32'h100, 1'b1);
    chk("rst_gate", 32'h0, 32'h0);
    rst = 1'b0;

    // Test 1: interrupt needs one sampling cycle before it is taken.
    bus.cp0_status_i = 32'h1000_0401;
    bus.cp0_cause_i  = 32'h0000_0400;
    mem(1'b1, 32'h0, 32'h100, 1'b0);
    chk("t1_sample", 32'h0, 32'h0);
    chk("t1_int", 32'h1, 32'h20);

    // Test 2: syscall beats overflow, taken during holdoff.
    bus.cp0_cause_i = 32'h0;
    mem(1'b1, 32'h900, 32'h200, 1'b1);
    chk("t2_syscall", 32'h8, 32'h20);

    // Test 3: ERET uses the WB-bypassed EPC.
    mem(1'b1, 32'h1000, 32'h250, 1'b0);
    bus.cp0_epc_i = 32'h300;
    wb(1'b1, 5'd14, 32'h400);
    chk("t3_eret_bypass", 32'he, 32'h400);

    // Test 4: interrupt masked for 4 holdoff cycles, then taken.
    wb(1'b0, 5'd0, 32'h0);
    bus.cp0_cause_i = 32'h0000_0400;
    mem(1'b1, 32'h0, 32'h260, 1'b0);
    for (int i = 0; i < 4; i++) chk("t4_masked", 32'h0, 32'h0);
    chk("t4_taken", 32'h1, 32'h20);

    // Test 5: bubbles ignore flags and hold off the pending interrupt.
    mem(1'b0, 32'h100, 32'h270, 1'b0);
    for (int i = 0; i < 4; i++) chk("t5_drain", 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) chk("t5_novalid", 32'h0, 32'h0);
    mem(1'b1, 32'h0, 32'h280, 1'b0);
    chk("t5_taken", 32'h1, 32'h20);

    // Test 6: async reset mid-holdoff returns to IDLE with a cleared sample.
    mem(1'b1, 32'h0, 32'h500, 1'b0);
    chk("t6_pre", 32'h0, 32'h0);
    rst = 1'b1;
    chk("t6_rst", 32'h0, 32'h0);
    rst = 1'b0;
    chk("t6_sample", 32'h0, 32'h0);
    chk("t6_idle_int", 32'h1, 32'h20);
    mem(1'b0, 32'h0, 32'h600, 1'b0);
    for (int i = 0; i < 4; i++) chk("t6_drain", 32'h0, 32'h0);
    mem(1'b1, 32'h0, 32'h600, 1'b0);
    wb(1'b1, 5'd12, 32'h1000_0400);
    chk("t6_ie_clear", 32'h0, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    chk("t6_resample", 32'h0, 32'h0);

    // Interrupt and syscall together: interrupt wins.
    mem(1'b1, 32'h100, 32'h700, 1'b1);
    chk("int_vs_syscall", 32'h1, 32'h20);

    // Remaining priority pairs, taken during holdoff.
    bus.cp0_cause_i = 32'h0;
    mem(1'b1, 32'h600, 32'h704, 1'b0);
    chk("pri_inval", 32'ha, 32'h20);
    mem(1'b1, 32'hc00, 32'h708, 1'b0);
    chk("pri_trap", 32'hd, 32'h20);
    mem(1'b1, 32'h1800, 32'h70c, 1'b0);
    chk("pri_ov", 32'hc, 32'h20);
    mem(1'b1, 32'h1000, 32'h710, 1'b1);
    chk("pri_eret", 32'he, 32'h300);
    mem(1'b1, 32'h0000_00ff, 32'h714, 1'b0);
    chk("no_flag", 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
